friscv_cache_rd_arbiter: RTL and testbench
==========================================

Name: friscv_cache_rd_arbiter

Overview:
Two-requester arbiter that shares one central-memory AXI4 read channel between the instruction-cache and data-cache memory controllers. It does round-robin on AR and tags the requester index into the ID MSB. R completions are routed back by that MSB. Per-requester outstanding counters throttle each side and produce an idle flag for FENCE/flush sequencing.

Parameters:
AXI_ADDR_W, 32, address width
AXI_ID_W, 8, requester-side ID width (memory side is AXI_ID_W+1)
AXI_DATA_W, 128, data width (one beat = one cache block)
OSTDREQ_NUM, 4, max outstanding reads per requester

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active high
s0_arvalid/s0_arready  in/out  1/1  requester 0 (icache) AR handshake
s0_araddr  in  AXI_ADDR_W  requester 0 address
s0_arprot  in  3  requester 0 protection
s0_arid  in  AXI_ID_W  requester 0 ID
s0_rvalid/s0_rready  out/in  1/1  requester 0 R handshake
s0_rid  out  AXI_ID_W  requester 0 completion ID
s0_rresp  out  2  requester 0 response
s0_rdata  out  AXI_DATA_W  requester 0 data
s1_*  same as s0_*  requester 1 (dcache)
m_arvalid/m_arready  out/in  1/1  memory AR handshake
m_araddr  out  AXI_ADDR_W  memory address
m_arprot  out  3  memory protection
m_arid  out  AXI_ID_W+1  memory ID
m_rvalid/m_rready  in/out  1/1  memory R handshake
m_rid  in  AXI_ID_W+1  memory completion ID
m_rresp  in  2  memory response
m_rdata  in  AXI_DATA_W  memory data
idle  out  1  no request pending or in flight
route_err  out  1  sticky: completion for a requester with zero outstanding

Behaviour:
- Reset (aresetn low or srst high):
  - state=ARB, rr_ptr=0, both counters=0, route_err=0.
  - m_arvalid=0, s*_arready=0, s*_rvalid=0, idle=1.
- Eligibility: req_i = s_i_arvalid && cnt_i < OSTDREQ_NUM.
- FSM ARB:
  - Grant selection:
    - Only one requester eligible: grant it.
    - Both eligible: grant rr_ptr.
  - Drive m_ar* combinationally from the grantee. AR path latency is 0 cycles.
  - m_arid = {grant_idx, s_arid}.
  - s_grant_arready = m_arready.
  - On handshake: cnt_grant++, rr_ptr = !grant_idx, stay in ARB.
  - On m_arvalid && !m_arready: register grant_idx and go to HOLD.
- FSM HOLD:
  - Selection frozen to the registered index; AXI AR stability is required.
  - The other requester gets arready=0.
  - On m_arready: cnt++, rr_ptr flips, go to ARB.
  - If the held requester drops arvalid (protocol violation), go to ARB with no count change.
- R path, combinational, 0 latency:
  - idx = m_rid[AXI_ID_W].
  - s_idx_rvalid = m_rvalid; s_idx_rid = m_rid[AXI_ID_W-1:0].
  - rresp and rdata fan out to both requesters; only the selected rvalid is high.
  - m_rready = s_idx_rready.
  - R handshake decrements cnt_idx.
- Counters:
  - Width is $clog2(OSTDREQ_NUM+1). They saturate by construction, never exceeding OSTDREQ_NUM.
  - AR and R handshakes on the same counter in the same cycle: net unchanged.
- Route error: R handshake with cnt_idx==0 sets route_err (sticky until reset). The counter stays 0 and the beat is still delivered.
- idle = cnt0==0 && cnt1==0 && !m_arvalid, combinational.
- Reset mid-transaction: counters clear. Late completions then raise route_err; upstream must drain before srst.

Decomposition:
- Shared package: typedef enum logic {ARB, HOLD} arb_fsm; localparam ARB_IDX_W=1.
- One sub-module friscv_cache_ostd_counter (inc, dec, count, full, zero), instantiated twice.

Test Plan:
- Single request: s0 addr 0x1000, id 3, m_arready=1 → same-cycle m_arid=0x003, cnt0=1, idle=0. Completion m_rid=0x003, rdata=0xAA.. → s0_rvalid only, s0_rid=3, cnt0=0, idle=1.
- Both request every cycle with m_arready=1 → grants alternate s0,s1,s0,s1; m_arid MSB toggles 0,1,0,1.
- m_arready held 0 for 3 cycles while s0 is granted and s1 requests → m_araddr stable, s1_arready=0, s0 handshakes on cycle 4, s1 granted cycle 5.
- s1 issues 4 reads without completions (OSTDREQ_NUM=4) → 5th s1 request blocked while s0 still granted. One s1 completion → s1 eligible next cycle.
- Same-cycle s0 AR handshake and s0 R handshake with cnt0=2 → cnt0 stays 2.
- m_rvalid with m_rid=0x105 while cnt1=0 → s1_rvalid=1, route_err=1 and stays 1; srst clears it.

Source files
------------

// File: rtl/friscv_cache_rd_arbiter_pkg.sv
// Shared types and helpers for the cache read-channel arbiter.
package friscv_cache_rd_arbiter_pkg;

  // Arbiter FSM: free arbitration, or AR held stable while memory stalls.
  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_fsm;

  // Width of the requester index carried in the memory-side ID MSB.
  localparam int ARB_IDX_W = 1;

  // Round-robin pick between two requesters; rr_ptr breaks ties.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic rr_ptr);
    logic pick;
    if (req0 && req1) begin
      pick = rr_ptr;
    end else if (req1) begin
      pick = 1'b1;
    end else begin
      pick = 1'b0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/friscv_cache_ostd_counter.sv
// Outstanding-read counter for one requester: counts AR grants up,
// R completions down, and never leaves the range [0, OSTDREQ_NUM].
module friscv_cache_ostd_counter #(
  parameter int OSTDREQ_NUM = 4,
  parameter int CNT_W       = $clog2(OSTDREQ_NUM + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             srst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(OSTDREQ_NUM);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  // Count register: simultaneous inc and dec leave the value unchanged.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      count <= CNT_ZERO;
    end else if (srst) begin
      count <= CNT_ZERO;
    end else if (inc && !dec && !full) begin
      count <= count + CNT_ONE;
    end else if (dec && !inc && !zero) begin
      count <= count - CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign full = (count == CNT_MAX);
  assign zero = (count == CNT_ZERO);

endmodule

// File: rtl/friscv_cache_rd_arbiter.sv
// Shares one memory AXI4 read channel between the icache (s0) and dcache
// (s1) controllers. AR is round-robin arbitrated with the requester index
// prepended to the ID; R beats are routed back using that ID MSB.
module friscv_cache_rd_arbiter
  import friscv_cache_rd_arbiter_pkg::*;
#(
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_W    = 8,
  parameter int AXI_DATA_W  = 128,
  parameter int OSTDREQ_NUM = 4
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  srst,
  // requester 0 (icache)
  input  logic                  s0_arvalid,
  output logic                  s0_arready,
  input  logic [AXI_ADDR_W-1:0] s0_araddr,
  input  logic [2:0]            s0_arprot,
  input  logic [AXI_ID_W-1:0]   s0_arid,
  output logic                  s0_rvalid,
  input  logic                  s0_rready,
  output logic [AXI_ID_W-1:0]   s0_rid,
  output logic [1:0]            s0_rresp,
  output logic [AXI_DATA_W-1:0] s0_rdata,
  // requester 1 (dcache)
  input  logic                  s1_arvalid,
  output logic                  s1_arready,
  input  logic [AXI_ADDR_W-1:0] s1_araddr,
  input  logic [2:0]            s1_arprot,
  input  logic [AXI_ID_W-1:0]   s1_arid,
  output logic                  s1_rvalid,
  input  logic                  s1_rready,
  output logic [AXI_ID_W-1:0]   s1_rid,
  output logic [1:0]            s1_rresp,
  output logic [AXI_DATA_W-1:0] s1_rdata,
  // memory side
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [AXI_ADDR_W-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic [AXI_ID_W:0]     m_arid,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [AXI_ID_W:0]     m_rid,
  input  logic [1:0]            m_rresp,
  input  logic [AXI_DATA_W-1:0] m_rdata,
  // status
  output logic                  idle,
  output logic                  route_err
);

  localparam int CNT_W = $clog2(OSTDREQ_NUM + 1);

  arb_fsm                 state;
  arb_fsm                 state_nxt;
  logic                   rr_ptr;
  logic [ARB_IDX_W-1:0]   hold_idx;
  logic [ARB_IDX_W-1:0]   grant_idx;
  logic                   grant_valid;
  logic                   ar_hs;
  logic                   active;
  logic                   req0;
  logic                   req1;
  logic                   r_idx;
  logic                   r_hs;
  logic                   route_hit;
  logic [CNT_W-1:0]       cnt0;
  logic [CNT_W-1:0]       cnt1;
  logic                   full0;
  logic                   full1;
  logic                   zero0;
  logic                   zero1;

  // Outputs are forced quiet whenever either reset is asserted.
  assign active = aresetn && !srst;

  assign req0 = s0_arvalid && !full0;
  assign req1 = s1_arvalid && !full1;

  // Grant selection and next-state: ARB picks freely, HOLD freezes the grantee.
  always_comb begin
    state_nxt   = state;
    grant_idx   = 1'b0;
    grant_valid = 1'b0;
    case (state)
      ARB: begin
        grant_idx   = rr_pick(req0, req1, rr_ptr);
        grant_valid = active && (req0 || req1);
        if (grant_valid && !m_arready) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = ARB;
        end
      end
      HOLD: begin
        grant_idx   = hold_idx;
        grant_valid = active && (hold_idx[0] ? s1_arvalid : s0_arvalid);
        // A dropped arvalid abandons the hold without counting anything.
        if (grant_valid && !m_arready) begin
          state_nxt = HOLD;
        end else begin
          state_nxt = ARB;
        end
      end
      default: begin
        state_nxt = ARB;
      end
    endcase
  end

  assign ar_hs = grant_valid && m_arready;

  assign m_arvalid  = grant_valid;
  assign m_araddr   = grant_idx[0] ? s1_araddr : s0_araddr;
  assign m_arprot   = grant_idx[0] ? s1_arprot : s0_arprot;
  assign m_arid     = {grant_idx, (grant_idx[0] ? s1_arid : s0_arid)};
  assign s0_arready = grant_valid && !grant_idx[0] && m_arready;
  assign s1_arready = grant_valid &&  grant_idx[0] && m_arready;

  // R routing by the ID MSB; data and response fan out to both sides.
  assign r_idx     = m_rid[AXI_ID_W];
  assign s0_rvalid = active && m_rvalid && !r_idx;
  assign s1_rvalid = active && m_rvalid &&  r_idx;
  assign s0_rid    = m_rid[AXI_ID_W-1:0];
  assign s1_rid    = m_rid[AXI_ID_W-1:0];
  assign s0_rresp  = m_rresp;
  assign s1_rresp  = m_rresp;
  assign s0_rdata  = m_rdata;
  assign s1_rdata  = m_rdata;
  assign m_rready  = active && (r_idx ? s1_rready : s0_rready);
  assign r_hs      = active && m_rvalid && m_rready;
  assign route_hit = r_hs && (r_idx ? zero1 : zero0);

  // FSM state, round-robin pointer, held grantee and sticky routing error.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= ARB;
      rr_ptr    <= 1'b0;
      hold_idx  <= 1'b0;
      route_err <= 1'b0;
    end else if (srst) begin
      state     <= ARB;
      rr_ptr    <= 1'b0;
      hold_idx  <= 1'b0;
      route_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        rr_ptr <= ~grant_idx[0];
      end
      if (state == ARB && grant_valid) begin
        hold_idx <= grant_idx;
      end
      if (route_hit) begin
        route_err <= 1'b1;
      end
    end
  end

  // Stray completions (counter already zero) must not disturb the count.
  friscv_cache_ostd_counter #(
    .OSTDREQ_NUM (OSTDREQ_NUM),
    .CNT_W       (CNT_W)
  ) u_cnt0 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .inc     (ar_hs && !grant_idx[0]),
    .dec     (r_hs && !r_idx && !zero0),
    .count   (cnt0),
    .full    (full0),
    .zero    (zero0)
  );

  friscv_cache_ostd_counter #(
    .OSTDREQ_NUM (OSTDREQ_NUM),
    .CNT_W       (CNT_W)
  ) u_cnt1 (
    .aclk    (aclk),
    .aresetn (aresetn),
    .srst    (srst),
    .inc     (ar_hs && grant_idx[0]),
    .dec     (r_hs && r_idx && !zero1),
    .count   (cnt1),
    .full    (full1),
    .zero    (zero1)
  );

  assign idle = zero0 && zero1 && !m_arvalid;

endmodule

// File: tb/tb_friscv_cache_rd_arbiter.sv
// Scoreboard bench for the cache read arbiter: expected AR/R beats are queued
// when driven and compared when the DUT presents them.
module tb_friscv_cache_rd_arbiter;

  logic         aclk = 1'b0;
  logic         aresetn, srst;
  logic         s0_arvalid, s0_arready, s0_rvalid, s0_rready;
  logic [31:0]  s0_araddr;
  logic [2:0]   s0_arprot;
  logic [7:0]   s0_arid, s0_rid;
  logic [1:0]   s0_rresp;
  logic [127:0] s0_rdata;
  logic         s1_arvalid, s1_arready, s1_rvalid, s1_rready;
  logic [31:0]  s1_araddr;
  logic [2:0]   s1_arprot;
  logic [7:0]   s1_arid, s1_rid;
  logic [1:0]   s1_rresp;
  logic [127:0] s1_rdata;
  logic         m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0]  m_araddr;
  logic [2:0]   m_arprot;
  logic [8:0]   m_arid, m_rid;
  logic [1:0]   m_rresp;
  logic [127:0] m_rdata;
  logic         idle, route_err;

  typedef struct packed { logic [31:0] addr; logic [8:0] id; } ar_exp_t;
  typedef struct packed { logic idx; logic [7:0] id; logic [127:0] data; } r_exp_t;
  ar_exp_t ar_q[$];
  r_exp_t  r_q[$];
  ar_exp_t ea;
  r_exp_t  er;

  int errors = 0;
  int checks = 0;

  friscv_cache_rd_arbiter dut (
    .aclk(aclk), .aresetn(aresetn), .srst(srst),
    .s0_arvalid(s0_arvalid), .s0_arready(s0_arready), .s0_araddr(s0_araddr),
    .s0_arprot(s0_arprot), .s0_arid(s0_arid), .s0_rvalid(s0_rvalid),
    .s0_rready(s0_rready), .s0_rid(s0_rid), .s0_rresp(s0_rresp), .s0_rdata(s0_rdata),
    .s1_arvalid(s1_arvalid), .s1_arready(s1_arready), .s1_araddr(s1_araddr),
    .s1_arprot(s1_arprot), .s1_arid(s1_arid), .s1_rvalid(s1_rvalid),
    .s1_rready(s1_rready), .s1_rid(s1_rid), .s1_rresp(s1_rresp), .s1_rdata(s1_rdata),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arprot(m_arprot), .m_arid(m_arid), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rid(m_rid), .m_rresp(m_rresp), .m_rdata(m_rdata),
    .idle(idle), .route_err(route_err)
  );

  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic clear_inputs();
    s0_arvalid = 1'b0; s0_araddr = 32'h0; s0_arprot = 3'b000; s0_arid = 8'h00; s0_rready = 1'b1;
    s1_arvalid = 1'b0; s1_araddr = 32'h0; s1_arprot = 3'b000; s1_arid = 8'h00; s1_rready = 1'b1;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = 9'h000; m_rresp = 2'b00; m_rdata = 128'h0;
  endtask

  task automatic srst_pulse();
    @(negedge aclk);
    clear_inputs();
    srst = 1'b1;
    @(negedge aclk);
    srst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    aresetn = 1'b0; srst = 1'b0;
    s0_arvalid = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1;
    #12;
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid: got %b want 0", m_arvalid); end
    checks++; if (s0_arready !== 1'b0) begin errors++; $display("FAIL rst_s0_arready: got %b want 0", s0_arready); end
    checks++; if (s0_rvalid !== 1'b0) begin errors++; $display("FAIL rst_s0_rvalid: got %b want 0", s0_rvalid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL rst_idle: got %b want 1", idle); end
    checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL rst_route_err: got %b want 0", route_err); end
    clear_inputs();
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk); #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL post_rst_idle: got %b want 1", idle); end
  endtask

  task automatic test_single();
    srst_pulse();
    s0_arvalid = 1'b1; s0_araddr = 32'h0000_1000; s0_arid = 8'h03; m_arready = 1'b1;
    ar_q.push_back('{addr: 32'h0000_1000, id: 9'h003});
    #1;
    checks++; if (s0_arready !== 1'b1 || s1_arready !== 1'b0) begin errors++; $display("FAIL single_arready: got %b%b want 01", s1_arready, s0_arready); end
    checks++; if (!(m_arvalid && m_arready)) begin errors++; $display("FAIL single_ar_hs: got m_arvalid=%b want 1", m_arvalid); end
    else begin
      ea = ar_q.pop_front();
      checks++; if (m_araddr !== ea.addr || m_arid !== ea.id) begin errors++; $display("FAIL single_ar: got %h/%h want %h/%h", m_araddr, m_arid, ea.addr, ea.id); end
    end
    @(negedge aclk);
    s0_arvalid = 1'b0; m_arready = 1'b0; #1;
    checks++; if (dut.u_cnt0.count !== 3'd1) begin errors++; $display("FAIL single_cnt0: got %0d want 1", dut.u_cnt0.count); end
    checks++; if (idle !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", idle); end
    @(negedge aclk);
    m_rvalid = 1'b1; m_rid = 9'h003; m_rdata = {16{8'hAA}};
    r_q.push_back('{idx: 1'b0, id: 8'h03, data: {16{8'hAA}}});
    #1;
    checks++; if (s0_rvalid !== 1'b1 || s1_rvalid !== 1'b0) begin errors++; $display("FAIL single_rvalid: got %b%b want 01", s1_rvalid, s0_rvalid); end
    else begin
      er = r_q.pop_front();
      checks++; if (s0_rid !== er.id || s0_rdata !== er.data) begin errors++; $display("FAIL single_r: got %h/%h want %h/%h", s0_rid, s0_rdata, er.id, er.data); end
    end
    @(negedge aclk);
    m_rvalid = 1'b0; #1;
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle_done: got %b want 1", idle); end
  endtask

  task automatic test_round_robin();
    int cnt_m [2];
    logic rr_m, e0, e1, g;
    srst_pulse();
    cnt_m[0] = 0; cnt_m[1] = 0; rr_m = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      s0_arvalid = 1'b1; s0_araddr = 32'h2000 + 32'(i) * 32'h10; s0_arid = 8'(i);
      s1_arvalid = 1'b1; s1_araddr = 32'h3000 + 32'(i) * 32'h10; s1_arid = 8'h40 + 8'(i);
      m_arready = 1'b1;
      e0 = cnt_m[0] < 4; e1 = cnt_m[1] < 4;
      g = (e0 && e1) ? rr_m : e1;
      ar_q.push_back('{addr: g ? s1_araddr : s0_araddr, id: {g, (g ? s1_arid : s0_arid)}});
      #1;
      checks++; if ({s1_arready, s0_arready} !== (g ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_grant%0d: got %b%b want g=%b", i, s1_arready, s0_arready, g); end
      if (m_arvalid && m_arready) begin
        ea = ar_q.pop_front();
        checks++; if (m_araddr !== ea.addr || m_arid !== ea.id) begin errors++; $display("FAIL rr_ar%0d: got %h/%h want %h/%h", i, m_araddr, m_arid, ea.addr, ea.id); end
      end else begin
        checks++; errors++; $display("FAIL rr_hs%0d: got m_arvalid=0 want 1", i);
        void'(ar_q.pop_front());
      end
      cnt_m[g] = cnt_m[g] + 1; rr_m = ~g;
    end
    @(negedge aclk);
    clear_inputs(); #1;
    checks++; if (dut.u_cnt1.count !== 3'(cnt_m[1])) begin errors++; $display("FAIL rr_cnt1: got %0d want %0d", dut.u_cnt1.count, cnt_m[1]); end
  endtask

  task automatic test_hold();
    srst_pulse();
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      s0_arvalid = 1'b1; s0_araddr = 32'h4000; s0_arid = 8'h11;
      s1_arvalid = 1'b1; s1_araddr = 32'h5000; s1_arid = 8'h22; m_arready = 1'b0;
      #1;
      checks++; if (m_araddr !== 32'h4000 || s1_arready !== 1'b0 || m_arvalid !== 1'b1) begin errors++; $display("FAIL hold_stall%0d: got addr=%h s1_arready=%b want 4000/0", c, m_araddr, s1_arready); end
    end
    @(negedge aclk);
    m_arready = 1'b1;
    ar_q.push_back('{addr: 32'h4000, id: 9'h011});
    #1;
    checks++; if (s0_arready !== 1'b1 || s1_arready !== 1'b0) begin errors++; $display("FAIL hold_release: got %b%b want 01", s1_arready, s0_arready); end
    ea = ar_q.pop_front();
    checks++; if (m_araddr !== ea.addr || m_arid !== ea.id) begin errors++; $display("FAIL hold_ar: got %h/%h want %h/%h", m_araddr, m_arid, ea.addr, ea.id); end
    @(negedge aclk);
    s0_arvalid = 1'b0;
    ar_q.push_back('{addr: 32'h5000, id: 9'h122});
    #1;
    checks++; if (s1_arready !== 1'b1) begin errors++; $display("FAIL hold_next_s1: got %b want 1", s1_arready); end
    ea = ar_q.pop_front();
    checks++; if (m_araddr !== ea.addr || m_arid !== ea.id) begin errors++; $display("FAIL hold_ar_s1: got %h/%h want %h/%h", m_araddr, m_arid, ea.addr, ea.id); end
    // held requester withdraws: nothing is issued that cycle, no count change
    @(negedge aclk);
    s1_arvalid = 1'b1; s1_araddr = 32'h6000; s1_arid = 8'h23; m_arready = 1'b0;
    @(negedge aclk);
    s1_arvalid = 1'b0; s0_arvalid = 1'b1; s0_araddr = 32'h7000; s0_arid = 8'h12; #1;
    checks++; if (m_arvalid !== 1'b0 || s0_arready !== 1'b0) begin errors++; $display("FAIL hold_drop: got m_arvalid=%b want 0", m_arvalid); end
    @(negedge aclk);
    m_arready = 1'b1;
    ar_q.push_back('{addr: 32'h7000, id: 9'h012});
    #1;
    ea = ar_q.pop_front();
    checks++; if (s0_arready !== 1'b1 || m_araddr !== ea.addr || m_arid !== ea.id) begin errors++; $display("FAIL hold_after_drop: got %b %h/%h want 1 %h/%h", s0_arready, m_araddr, m_arid, ea.addr, ea.id); end
    @(negedge aclk);
    clear_inputs(); #1;
    checks++; if (dut.u_cnt1.count !== 3'd1 || dut.u_cnt0.count !== 3'd2) begin errors++; $display("FAIL hold_counts: got %0d/%0d want 2/1", dut.u_cnt0.count, dut.u_cnt1.count); end
  endtask

  task automatic test_throttle();
    logic [127:0] d;
    srst_pulse();
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s1_arvalid = 1'b1; s1_araddr = 32'h8000 + 32'(i) * 32'h40; s1_arid = 8'h30 + 8'(i); m_arready = 1'b1;
      ar_q.push_back('{addr: s1_araddr, id: {1'b1, s1_arid}});
      #1;
      ea = ar_q.pop_front();
      checks++; if (s1_arready !== 1'b1 || m_arid !== ea.id || m_araddr !== ea.addr) begin errors++; $display("FAIL thr_fill%0d: got %b %h want 1 %h", i, s1_arready, m_arid, ea.id); end
    end
    @(negedge aclk);
    s0_arvalid = 1'b1; s0_araddr = 32'h9000; s0_arid = 8'h01;
    s1_araddr = 32'h8100; s1_arid = 8'h34;
    ar_q.push_back('{addr: 32'h9000, id: 9'h001});
    #1;
    ea = ar_q.pop_front();
    checks++; if (s1_arready !== 1'b0 || s0_arready !== 1'b1 || m_arid !== ea.id) begin errors++; $display("FAIL thr_block: got s1=%b s0=%b id=%h want 0/1/%h", s1_arready, s0_arready, m_arid, ea.id); end
    @(negedge aclk);
    d = {$urandom, $urandom, $urandom, $urandom};
    s0_arvalid = 1'b0; m_arready = 1'b0;
    m_rvalid = 1'b1; m_rid = 9'h130; m_rdata = d;
    r_q.push_back('{idx: 1'b1, id: 8'h30, data: d});
    #1;
    checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL thr_full: got m_arvalid=%b want 0", m_arvalid); end
    er = r_q.pop_front();
    checks++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || s1_rid !== er.id || s1_rdata !== er.data) begin errors++; $display("FAIL thr_r: got %b %h want 1 %h", s1_rvalid, s1_rid, er.id); end
    @(negedge aclk);
    m_rvalid = 1'b0; m_arready = 1'b1;
    ar_q.push_back('{addr: 32'h8100, id: 9'h134});
    #1;
    ea = ar_q.pop_front();
    checks++; if (s1_arready !== 1'b1 || m_arid !== ea.id || m_araddr !== ea.addr) begin errors++; $display("FAIL thr_resume: got %b %h want 1 %h", s1_arready, m_arid, ea.id); end
    @(negedge aclk);
    clear_inputs();
  endtask

  task automatic test_same_cycle();
    srst_pulse();
    for (int i = 0; i < 2; i++) begin
      @(negedge aclk);
      s0_arvalid = 1'b1; s0_araddr = 32'hA000 + 32'(i) * 32'h10; s0_arid = 8'h50 + 8'(i); m_arready = 1'b1;
    end
    @(negedge aclk);
    s0_arid = 8'h52; s0_araddr = 32'hA020;
    m_rvalid = 1'b1; m_rid = 9'h050; m_rdata = {4{32'hC0DE_0050}};
    ar_q.push_back('{addr: 32'hA020, id: 9'h052});
    r_q.push_back('{idx: 1'b0, id: 8'h50, data: {4{32'hC0DE_0050}}});
    #1;
    ea = ar_q.pop_front();
    checks++; if (s0_arready !== 1'b1 || m_arid !== ea.id) begin errors++; $display("FAIL same_ar: got %b %h want 1 %h", s0_arready, m_arid, ea.id); end
    er = r_q.pop_front();
    checks++; if (s0_rvalid !== 1'b1 || m_rready !== 1'b1 || s0_rid !== er.id || s0_rdata !== er.data) begin errors++; $display("FAIL same_r: got %b %h want 1 %h", s0_rvalid, s0_rid, er.id); end
    @(negedge aclk);
    clear_inputs(); #1;
    checks++; if (dut.u_cnt0.count !== 3'd2 || idle !== 1'b0) begin errors++; $display("FAIL same_cnt0: got %0d idle=%b want 2 idle=0", dut.u_cnt0.count, idle); end
  endtask

  task automatic test_route_err();
    srst_pulse();
    m_rvalid = 1'b1; m_rid = 9'h105; m_rresp = 2'b10; m_rdata = {8{16'hBEEF}}; s1_rready = 1'b0;
    #1;
    checks++; if (s1_rvalid !== 1'b1 || s0_rvalid !== 1'b0 || m_rready !== 1'b0) begin errors++; $display("FAIL rerr_bp: got s1=%b s0=%b rready=%b want 1/0/0", s1_rvalid, s0_rvalid, m_rready); end
    checks++; if (s0_rresp !== 2'b10 || s1_rresp !== 2'b10 || s0_rdata !== {8{16'hBEEF}}) begin errors++; $display("FAIL rerr_fanout: got %b/%b want 10/10", s0_rresp, s1_rresp); end
    @(negedge aclk);
    s1_rready = 1'b1; #1;
    checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL rerr_no_hs: got %b want 0", route_err); end
    checks++; if (s1_rid !== 8'h05 || m_rready !== 1'b1) begin errors++; $display("FAIL rerr_rid: got %h/%b want 05/1", s1_rid, m_rready); end
    @(negedge aclk);
    m_rvalid = 1'b0; #1;
    checks++; if (route_err !== 1'b1 || dut.u_cnt1.count !== 3'd0) begin errors++; $display("FAIL rerr_set: got %b cnt1=%0d want 1/0", route_err, dut.u_cnt1.count); end
    @(negedge aclk); #1;
    checks++; if (route_err !== 1'b1) begin errors++; $display("FAIL rerr_sticky: got %b want 1", route_err); end
    @(negedge aclk);
    srst = 1'b1; s0_arvalid = 1'b1; m_arready = 1'b1; #1;
    checks++; if (m_arvalid !== 1'b0 || s0_arready !== 1'b0 || idle !== 1'b1) begin errors++; $display("FAIL srst_quiet: got %b/%b/%b want 0/0/1", m_arvalid, s0_arready, idle); end
    @(negedge aclk);
    srst = 1'b0; clear_inputs(); #1;
    checks++; if (route_err !== 1'b0) begin errors++; $display("FAIL rerr_clear: got %b want 0", route_err); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_throttle();
    test_same_cycle();
    test_route_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
